// File: rtl/mix_out_collect.sv
// Gathers N_CHUNK chunks of DATA_N elements into one HID_DIM-element word and
// presents it on a registered valid/ready output that can hold one word.
module mix_out_collect #(
  parameter int N_LEN   = 16,
  parameter int DATA_N  = 2,
  parameter int N_CHUNK = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              run,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_N*N_LEN-1:0]           in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_N*N_CHUNK*N_LEN-1:0]   out_data,
  output logic                              busy
);

  localparam int CW    = DATA_N * N_LEN;
  localparam int WW    = CW * N_CHUNK;
  localparam int CNT_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  // Handshake rules: a transfer happens on a rising edge where valid & ready
  // are both high. in_ready depends only on run and state, never on in_valid.
  // out_valid/out_data are registered and do not change while out_valid=1 and
  // out_ready=0.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WW-1:0]    asm_buf_q;
  logic [WW-1:0]    out_data_q;
  logic             out_valid_q;
  logic [WW-1:0]    word_d;

  logic accept;
  logic last_chunk;
  logic out_free;

  assign in_ready   = run & (state_q == FILL);
  assign accept     = in_valid & in_ready;
  assign last_chunk = (cnt_q == CNT_W'(N_CHUNK - 1));
  assign out_free   = ~out_valid_q | out_ready;

  // The completing word bypasses asm_buf so the last chunk costs no extra cycle.
  always_comb begin
    word_d = asm_buf_q;
    word_d[(N_CHUNK-1)*CW +: CW] = in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      asm_buf_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= FILL;

        FILL: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            for (int k = 0; k < N_CHUNK; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                asm_buf_q[k*CW +: CW] <= in_data;
              end
            end
            if (last_chunk) begin
              cnt_q <= '0;
              if (out_free) begin
                out_data_q  <= word_d;
                out_valid_q <= 1'b1;
              end else begin
                state_q <= STALL;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        // Complete word parked in asm_buf until the output register frees up.
        STALL: begin
          if (out_ready) begin
            out_data_q  <= asm_buf_q;
            out_valid_q <= 1'b1;
            state_q     <= FILL;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mix_out_collect.sv
// Directed bench for mix_out_collect: hand-computed words, an output scoreboard
// and a hold-stability monitor on the output handshake.
module tb_mix_out_collect;

  localparam int W = 128;
  localparam logic [W-1:0] W_LO = 128'hA0A00003_A0A00002_A0A00001_A0A00000;
  localparam logic [W-1:0] W_HI = 128'hA0A00007_A0A00006_A0A00005_A0A00004;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  mix_out_collect dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k);
    int waited;
    waited = 0;
    in_data  = 32'hA0A0_0000 + 32'(k);
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // scoreboard: a word is consumed at the edge following a negedge with valid & ready
  always @(negedge clk) begin
    if (rst_n && run && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", 1, 0);
      else check("sb_word", out_data, exp_q.pop_front());
    end
    if (prev_hold) check("hold_stable", out_data, prev_data);
    prev_hold = rst_n && run && out_valid && !out_ready;
    prev_data = out_data;
  end

  initial begin
    rst_n     = 1'b0;
    run       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b1;

    // 1: reset
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 1);

    // 2: back-to-back word with free output
    exp_q.push_back(W_LO);
    for (int k = 0; k < 4; k++) send(k);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, W_LO);
    tick();
    check("t2_valid_drop", out_valid, 0);
    check("t2_data_hold", out_data, W_LO);

    // 3: output back-pressure into STALL, then release
    out_ready = 1'b0;
    exp_q.push_back(W_LO);
    exp_q.push_back(W_HI);
    for (int k = 0; k < 8; k++) send(k);
    check("t3_stall_in_ready", in_ready, 0);
    check("t3_stall_data", out_data, W_LO);
    check("t3_stall_valid", out_valid, 1);
    tick();
    tick();
    check("t3_stall_in_ready2", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("t3_release_data", out_data, W_HI);
    check("t3_release_valid", out_valid, 1);
    check("t3_release_in_ready", in_ready, 1);
    tick();
    check("t3_drain_valid", out_valid, 0);

    // 4: input gap between c1 and c2
    exp_q.push_back(W_LO);
    send(0);
    send(1);
    for (int i = 0; i < 3; i++) tick();
    check("t4_gap_valid", out_valid, 0);
    send(2);
    check("t4_pre_last_valid", out_valid, 0);
    send(3);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, W_LO);
    tick();

    // 5: run drop discards a partial word
    send(0);
    send(1);
    run = 1'b0;
    tick();
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_out_data", out_data, 0);
    run = 1'b1;
    tick();
    exp_q.push_back(W_HI);
    for (int k = 4; k < 8; k++) send(k);
    check("t5_valid", out_valid, 1);
    check("t5_data", out_data, W_HI);
    tick();

    // 6: reset while in STALL
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(k);
    check("t6_stall_in_ready", in_ready, 0);
    rst_n = 1'b0;
    tick();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_data", out_data, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    exp_q.push_back(W_LO);
    for (int k = 0; k < 4; k++) send(k);
    check("t6_valid", out_valid, 1);
    check("t6_data", out_data, W_LO);
    tick();
    tick();

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
